// File: rtl/ifm_window_buf.sv
// KxK input-feature-map window buffer: FILL builds the window row by row, shift opcodes slide it one step.
// Define IFM_WIN_ZERO_PAD_EN to add port pad_zero, which makes shifts insert zeros instead of cmd_data.
module ifm_window_buf #(
   parameter int K  = 3,
   parameter int DW = 8,
   parameter int PW = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [2:0]          cmd,
   input  logic [K*DW-1:0]     cmd_data,
`ifdef IFM_WIN_ZERO_PAD_EN
   input  logic                pad_zero,
`endif
   input  logic                pe_stall,
   output logic [K*K*DW-1:0]   win_data,
   output logic                win_valid,
   output logic [PW-1:0]       win_x,
   output logic [PW-1:0]       win_y,
   output logic                err_cmd
);

   localparam int CW = $clog2(K);

   typedef enum logic [1:0] {ST_EMPTY, ST_FILL, ST_VALID} state_t;
   typedef enum logic [2:0] {
      OP_NOP   = 3'b000, OP_RIGHT = 3'b001, OP_DOWN = 3'b010, OP_UP    = 3'b011,
      OP_LEFT  = 3'b100, OP_HOLD  = 3'b101, OP_FILL = 3'b110, OP_CLEAR = 3'b111
   } op_t;

   state_t          state_q, state_d;
   op_t             op;
   logic [CW-1:0]   fill_cnt_q, fill_cnt_d;
   logic [DW-1:0]   win_q [K][K];
   logic [DW-1:0]   win_d [K][K];
   logic [DW-1:0]   fill_lane [K];
   logic [DW-1:0]   ins_lane [K];
   logic            valid_d, err_d, accept, shift_op, pad;
   logic [PW-1:0]   x_d, y_d;
   logic [CW-1:0]   row;

   assign op        = op_t'(cmd);
   assign cmd_ready = ~pe_stall;
   assign accept    = cmd_valid & cmd_ready;
   assign shift_op  = (op == OP_RIGHT) || (op == OP_LEFT) || (op == OP_DOWN) || (op == OP_UP);
`ifdef IFM_WIN_ZERO_PAD_EN
   assign pad = pad_zero;
`else
   assign pad = 1'b0;
`endif

   // FILL always takes cmd_data; only shifts see the zero-pad substitution.
   always_comb begin
      for (int j = 0; j < K; j++) begin
         fill_lane[j] = cmd_data[j*DW +: DW];
         ins_lane[j]  = pad ? '0 : cmd_data[j*DW +: DW];
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_EMPTY;
      // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values together.
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
      state_d = state_q;
      if (accept) begin
         case (op)
            OP_FILL:  state_d = (state_q == ST_FILL && fill_cnt_q == CW'(K-1)) ? ST_VALID : ST_FILL;
            OP_CLEAR: state_d = ST_EMPTY;
            default:  state_d = state_q;
         endcase
      end
   end

   // Output logic: next window, flags and counters
   always_comb begin
      win_d      = win_q;
      valid_d    = win_valid;
      x_d        = win_x;
      y_d        = win_y;
      fill_cnt_d = fill_cnt_q;
      err_d      = 1'b0;
      row        = (state_q == ST_FILL) ? fill_cnt_q : '0;
      if (accept) begin
         if (shift_op && state_q != ST_VALID) begin
            err_d = 1'b1;
         end else begin
            case (op)
               OP_FILL: begin
                  for (int c = 0; c < K; c++) win_d[row][c] = fill_lane[c];
                  if (state_q != ST_FILL) begin
                     valid_d    = 1'b0;
                     x_d        = '0;
                     y_d        = '0;
                     fill_cnt_d = CW'(1);
                  end else if (fill_cnt_q == CW'(K-1)) begin
                     valid_d    = 1'b1;
                     fill_cnt_d = '0;
                  end else begin
                     fill_cnt_d = fill_cnt_q + CW'(1);
                  end
               end
               OP_RIGHT: begin
                  for (int r = 0; r < K; r++) begin
                     for (int c = 0; c < K-1; c++) win_d[r][c] = win_q[r][c+1];
                     win_d[r][K-1] = ins_lane[r];
                  end
                  x_d = win_x + PW'(1);
               end
               OP_LEFT: begin
                  for (int r = 0; r < K; r++) begin
                     for (int c = 1; c < K; c++) win_d[r][c] = win_q[r][c-1];
                     win_d[r][0] = ins_lane[r];
                  end
                  x_d = win_x - PW'(1);
               end
               OP_DOWN: begin
                  for (int c = 0; c < K; c++) begin
                     for (int r = 0; r < K-1; r++) win_d[r][c] = win_q[r+1][c];
                     win_d[K-1][c] = ins_lane[c];
                  end
                  y_d = win_y + PW'(1);
               end
               OP_UP: begin
                  for (int c = 0; c < K; c++) begin
                     for (int r = 1; r < K; r++) win_d[r][c] = win_q[r-1][c];
                     win_d[0][c] = ins_lane[c];
                  end
                  y_d = win_y - PW'(1);
               end
               OP_CLEAR: begin
                  for (int r = 0; r < K; r++)
                     for (int c = 0; c < K; c++) win_d[r][c] = '0;
                  valid_d    = 1'b0;
                  x_d        = '0;
                  y_d        = '0;
                  fill_cnt_d = '0;
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the window array is reset explicitly because reset must clear the visible window, unlike a plain RAM.
         for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++) win_q[r][c] <= '0;
         win_valid  <= 1'b0;
         win_x      <= '0;
         win_y      <= '0;
         fill_cnt_q <= '0;
         err_cmd    <= 1'b0;
      end else begin
         win_q      <= win_d;
         win_valid  <= valid_d;
         win_x      <= x_d;
         win_y      <= y_d;
         fill_cnt_q <= fill_cnt_d;
         err_cmd    <= err_d;
      end
   end

   for (genvar r = 0; r < K; r++) begin : g_row
      for (genvar c = 0; c < K; c++) begin : g_col
         assign win_data[(r*K+c)*DW +: DW] = win_q[r][c];
      end
   end

endmodule

// File: tb/tb_ifm_window_buf.sv
// Self-checking bench for ifm_window_buf (K=3, DW=8, PW=8): vector table, corner sequences, random vs model.
// Define IFM_WIN_ZERO_PAD_EN to also exercise the zero-padded shifts.
module tb_ifm_window_buf;

   localparam logic [2:0] NOP = 3'b000, RIGHT = 3'b001, DOWN = 3'b010, UP = 3'b011,
                          LEFT = 3'b100, HOLD = 3'b101, FILL = 3'b110, CLEAR = 3'b111;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [2:0]  cmd = 3'b000;
   logic [23:0] cmd_data = '0;
   logic        pe_stall = 1'b0;
   logic [71:0] win_data;
   logic        win_valid;
   logic [7:0]  win_x, win_y;
   logic        err_cmd;
`ifdef IFM_WIN_ZERO_PAD_EN
   logic        pad_zero = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   ifm_window_buf #(.K(3), .DW(8), .PW(8)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
      .cmd_data(cmd_data),
`ifdef IFM_WIN_ZERO_PAD_EN
      .pad_zero(pad_zero),
`endif
      .pe_stall(pe_stall), .win_data(win_data), .win_valid(win_valid),
      .win_x(win_x), .win_y(win_y), .err_cmd(err_cmd)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]  op;
      logic [23:0] data;
      logic [71:0] win;
      logic        valid;
      logic [7:0]  x;
      logic [7:0]  y;
      logic        err;
   } vec_t;

   function automatic logic [23:0] l3(input int a, input int b, input int c);
      return {8'(c), 8'(b), 8'(a)};
   endfunction

   function automatic logic [71:0] w9(input int e0, e1, e2, e3, e4, e5, e6, e7, e8);
      return {8'(e8), 8'(e7), 8'(e6), 8'(e5), 8'(e4), 8'(e3), 8'(e2), 8'(e1), 8'(e0)};
   endfunction

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: window as a plain 2-D array, state as 0=empty 1=fill 2=valid
   int m_win [3][3];
   int m_state, m_cnt, m_x, m_y;
   bit m_valid, m_err;

   task automatic model_reset();
      for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) m_win[r][c] = 0;
      m_state = 0; m_cnt = 0; m_x = 0; m_y = 0; m_valid = 0; m_err = 0;
   endtask

   task automatic model_step(input logic v, input logic s, input logic [2:0] op,
                             input logic [23:0] d, input logic pad);
      int ln [3];
      int old [3][3];
      int row;
      m_err = 0;
      if (!v || s) return;
      for (int j = 0; j < 3; j++) ln[j] = int'(d[j*8 +: 8]);
      old = m_win;
      case (op)
         FILL: begin
            row = (m_state == 1) ? m_cnt : 0;
            if (m_state != 1) begin m_valid = 0; m_x = 0; m_y = 0; end
            for (int c = 0; c < 3; c++) m_win[row][c] = ln[c];
            if (row == 2) begin m_state = 2; m_valid = 1; m_cnt = 0; end
            else begin m_state = 1; m_cnt = row + 1; end
         end
         CLEAR: model_reset();
         RIGHT, LEFT, DOWN, UP: begin
            if (m_state != 2) m_err = 1;
            else begin
               if (pad) for (int j = 0; j < 3; j++) ln[j] = 0;
               for (int r = 0; r < 3; r++)
                  for (int c = 0; c < 3; c++)
                     case (op)
                        RIGHT:   m_win[r][c] = (c == 2) ? ln[r] : old[r][c+1];
                        LEFT:    m_win[r][c] = (c == 0) ? ln[r] : old[r][c-1];
                        DOWN:    m_win[r][c] = (r == 2) ? ln[c] : old[r+1][c];
                        default: m_win[r][c] = (r == 0) ? ln[c] : old[r-1][c];
                     endcase
               if (op == RIGHT) m_x = (m_x + 1) % 256;
               if (op == LEFT)  m_x = (m_x + 255) % 256;
               if (op == DOWN)  m_y = (m_y + 1) % 256;
               if (op == UP)    m_y = (m_y + 255) % 256;
            end
         end
         default: ;
      endcase
   endtask

   function automatic logic [71:0] model_pack();
      logic [71:0] res;
      for (int e = 0; e < 9; e++) res[e*8 +: 8] = 8'(m_win[e/3][e%3]);
      return res;
   endfunction

   task automatic compare_model(input string tag);
      check({tag, " win_data"},  win_data,  model_pack());
      check({tag, " win_valid"}, 72'(win_valid), 72'(m_valid));
      check({tag, " win_x"},     72'(win_x), 72'(m_x));
      check({tag, " win_y"},     72'(win_y), 72'(m_y));
      check({tag, " err_cmd"},   72'(err_cmd), 72'(m_err));
   endtask

   task automatic beat(input logic [2:0] op, input logic [23:0] d);
      cmd_valid = 1'b1; cmd = op; cmd_data = d;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1; cmd_valid = 1'b0; pe_stall = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   vec_t vecs [11];

   initial begin
      vecs[0]  = '{FILL,  l3(1,2,3),    w9(1,2,3,0,0,0,0,0,0),        1'b0, 8'd0,   8'd0, 1'b0};
      vecs[1]  = '{FILL,  l3(4,5,6),    w9(1,2,3,4,5,6,0,0,0),        1'b0, 8'd0,   8'd0, 1'b0};
      vecs[2]  = '{FILL,  l3(7,8,9),    w9(1,2,3,4,5,6,7,8,9),        1'b1, 8'd0,   8'd0, 1'b0};
      vecs[3]  = '{RIGHT, l3(10,11,12), w9(2,3,10,5,6,11,8,9,12),     1'b1, 8'd1,   8'd0, 1'b0};
      vecs[4]  = '{LEFT,  l3(1,4,7),    w9(1,2,3,4,5,6,7,8,9),        1'b1, 8'd0,   8'd0, 1'b0};
      vecs[5]  = '{DOWN,  l3(20,21,22), w9(4,5,6,7,8,9,20,21,22),     1'b1, 8'd0,   8'd1, 1'b0};
      vecs[6]  = '{UP,    l3(1,2,3),    w9(1,2,3,4,5,6,7,8,9),        1'b1, 8'd0,   8'd0, 1'b0};
      vecs[7]  = '{LEFT,  l3(30,31,32), w9(30,1,2,31,4,5,32,7,8),     1'b1, 8'd255, 8'd0, 1'b0};
      vecs[8]  = '{CLEAR, l3(0,0,0),    w9(0,0,0,0,0,0,0,0,0),        1'b0, 8'd0,   8'd0, 1'b0};
      vecs[9]  = '{RIGHT, l3(5,5,5),    w9(0,0,0,0,0,0,0,0,0),        1'b0, 8'd0,   8'd0, 1'b1};
      vecs[10] = '{HOLD,  l3(9,9,9),    w9(0,0,0,0,0,0,0,0,0),        1'b0, 8'd0,   8'd0, 1'b0};

      do_reset();
      check("reset win_data", win_data, 72'd0);
      check("reset win_valid", 72'(win_valid), 72'd0);
      check("reset win_x", 72'(win_x), 72'd0);
      check("reset err_cmd", 72'(err_cmd), 72'd0);
      check("reset cmd_ready", 72'(cmd_ready), 72'd1);

      for (int i = 0; i < 11; i++) begin
         beat(vecs[i].op, vecs[i].data);
         check($sformatf("vec%0d win_data", i), win_data, vecs[i].win);
         check($sformatf("vec%0d win_valid", i), 72'(win_valid), 72'(vecs[i].valid));
         check($sformatf("vec%0d win_x", i), 72'(win_x), 72'(vecs[i].x));
         check($sformatf("vec%0d win_y", i), 72'(win_y), 72'(vecs[i].y));
         check($sformatf("vec%0d err_cmd", i), 72'(err_cmd), 72'(vecs[i].err));
      end

      // Shift straight after reset is rejected with a single-cycle error pulse
      do_reset();
      beat(RIGHT, l3(10,11,12));
      check("rej err pulse", 72'(err_cmd), 72'd1);
      check("rej win_data", win_data, 72'd0);
      check("rej win_valid", 72'(win_valid), 72'd0);
      @(posedge clk); #1;
      check("rej err one cycle", 72'(err_cmd), 72'd0);

      // Shift in mid-FILL is rejected and the fill continues at the right row
      beat(FILL, l3(1,2,3));
      beat(DOWN, l3(7,7,7));
      check("fill rej err", 72'(err_cmd), 72'd1);
      beat(FILL, l3(4,5,6));
      beat(FILL, l3(7,8,9));
      check("fill rej resume", win_data, w9(1,2,3,4,5,6,7,8,9));
      check("fill rej valid", 72'(win_valid), 72'd1);

      // Stall holds the beat for 4 cycles, then it is taken exactly once
      cmd_valid = 1'b1; cmd = RIGHT; cmd_data = l3(10,11,12); pe_stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1 check($sformatf("stall%0d cmd_ready", i), 72'(cmd_ready), 72'd0);
         @(posedge clk); #1;
         check($sformatf("stall%0d win_data", i), win_data, w9(1,2,3,4,5,6,7,8,9));
         check($sformatf("stall%0d win_x", i), 72'(win_x), 72'd0);
         check($sformatf("stall%0d win_valid", i), 72'(win_valid), 72'd1);
      end
      pe_stall = 1'b0;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      check("release win_data", win_data, w9(2,3,10,5,6,11,8,9,12));
      check("release win_x", 72'(win_x), 72'd1);
      @(posedge clk); #1;
      check("release once win_x", 72'(win_x), 72'd1);

      // Reset asserted mid-FILL clears everything immediately and beats with rst high are ignored
      beat(FILL, l3(1,2,3));
      beat(FILL, l3(4,5,6));
      #2 rst = 1'b1;
      #1 check("async rst win_data", win_data, 72'd0);
      check("async rst win_x", 72'(win_x), 72'd0);
      beat(FILL, l3(9,9,9));
      check("rst wins win_data", win_data, 72'd0);
      rst = 1'b0;
      beat(FILL, l3(5,6,7));
      check("refill row0", win_data, w9(5,6,7,0,0,0,0,0,0));
      check("refill not valid", 72'(win_valid), 72'd0);

`ifdef IFM_WIN_ZERO_PAD_EN
      do_reset();
      pad_zero = 1'b1;
      beat(FILL, l3(1,2,3));
      beat(FILL, l3(4,5,6));
      beat(FILL, l3(7,8,9));
      check("pad fill ignores pad", win_data, w9(1,2,3,4,5,6,7,8,9));
      beat(RIGHT, l3(10,11,12));
      check("pad right win_data", win_data, w9(2,3,0,5,6,0,8,9,0));
      check("pad right win_x", 72'(win_x), 72'd1);
      pad_zero = 1'b0;
`endif

      // Randomised run against the reference model
      do_reset();
      model_reset();
      for (int i = 0; i < 1500; i++) begin
         logic v, s, p;
         logic [2:0] op;
         logic [23:0] d;
         v  = ($urandom_range(0, 9) < 8);
         s  = ($urandom_range(0, 9) < 2);
         op = 3'($urandom_range(0, 7));
         if (op == CLEAR && $urandom_range(0, 3) != 0) op = FILL;
         d  = 24'($urandom);
         p  = 1'b0;
`ifdef IFM_WIN_ZERO_PAD_EN
         p  = 1'($urandom_range(0, 1));
         pad_zero = p;
`endif
         cmd_valid = v; pe_stall = s; cmd = op; cmd_data = d;
         #1 check("rand cmd_ready", 72'(cmd_ready), 72'(!s));
         @(posedge clk);
         model_step(v, s, op, d, p);
         #1 compare_model($sformatf("rand%0d", i));
      end
      cmd_valid = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
